// File: rtl/spk_train_packer.sv
// spk_train_packer
//   Packs the per-lane spike bits of an activation sweep into dense
//   OUTPUT_FRAME_SIZE-bit spike trains. Each train is written to the spike RAM
//   at channel*TIME_STEPS + time_step. The block is double-buffered: a capture
//   buffer fills while the write buffer drains one lane per cycle.
//   post_syn_RAM_loaded pulses once the layer is finished and every frame is
//   written.
// Ports
//   clk, rst            clock, async active-low reset
//   en_activ            sweep bit valid
//   neur_idx            neuron index of the sweep bit
//   spk_in[EC_SIZE]     spike bit per lane (lane l = channel oc_phase*EC_SIZE+l)
//   oc_phase, time_step tag of the sweep, latched at neur_idx 0
//   layer_done          pulse: controller finished every oc/time step
//   ram_we/addr/wdata   registered spike RAM write port
//   frame_spk_cnt       popcount of ram_wdata, valid with ram_we
//   post_syn_RAM_loaded pulse: all frames of the image written
//   overflow_err        sticky: a sweep completed while the write buffer was busy

// One channel lane: capture train plus its write-side copy.
module spk_train_lane #(
  parameter int FS = 784,
  parameter int NW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_bit_i,   // qualified sweep bit
  input  logic [NW-1:0] idx_i,
  input  logic          spk_i,
  input  logic          clr_i,      // sweep completed (swap or drop)
  input  logic          load_i,     // swap into write buffer
  output logic [FS-1:0] wr_o
);
  logic [FS-1:0] cap_q, cap_d, wr_q;

  // The completing bit is merged here so the swap edge carries it along.
  always_comb begin
    cap_d = cap_q;
    if (wr_bit_i) cap_d[idx_i] = spk_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q <= '0;
      wr_q  <= '0;
    end else begin
      cap_q <= clr_i ? '0 : cap_d;
      if (load_i) wr_q <= cap_d;
    end
  end

  assign wr_o = wr_q;
endmodule

module spk_train_packer #(
  parameter int TIME_STEPS         = 10,
  parameter int OUTPUT_CHANNELS    = 32,
  parameter int EC_SIZE            = 4,
  parameter int OUTPUT_FRAME_WIDTH = 28,
  parameter int OUTPUT_FRAME_SIZE  = OUTPUT_FRAME_WIDTH*OUTPUT_FRAME_WIDTH,
  parameter int ADDR_W             = $clog2(OUTPUT_CHANNELS*TIME_STEPS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en_activ,
  input  logic [$clog2(OUTPUT_FRAME_SIZE)-1:0] neur_idx,
  input  logic [EC_SIZE-1:0]                   spk_in,
  input  logic [$clog2(OUTPUT_CHANNELS)+1:0]   oc_phase,
  input  logic [$clog2(TIME_STEPS)-1:0]        time_step,
  input  logic                                 layer_done,
  output logic                                 ram_we,
  output logic [ADDR_W-1:0]                    ram_addr,
  output logic [OUTPUT_FRAME_SIZE-1:0]         ram_wdata,
  output logic [$clog2(OUTPUT_FRAME_SIZE):0]   frame_spk_cnt,
  output logic                                 post_syn_RAM_loaded,
  output logic                                 overflow_err
);
  localparam int FS  = OUTPUT_FRAME_SIZE;
  localparam int NW  = $clog2(FS);
  localparam int CW  = NW + 1;
  localparam int OCW = $clog2(OUTPUT_CHANNELS) + 2;
  localparam int TW  = $clog2(TIME_STEPS);
  localparam int LW  = (EC_SIZE > 1) ? $clog2(EC_SIZE) : 1;

  typedef struct packed {
    logic [OCW-1:0] oc;
    logic [TW-1:0]  t;
  } tag_t;

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DONE} wstate_e;

  wstate_e state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic          wr_full_q, wr_full_d;
  logic          insweep_q, insweep_d;
  logic          pend_q, pend_d;
  tag_t          cap_tag_q, cap_tag_d, wr_tag_q;

  logic          bit_vld, cmpl, first, last_issue, swap, drop;
  logic [EC_SIZE-1:0][FS-1:0] wr_bufs;

  int                ch;
  logic              issue_we;
  logic [ADDR_W-1:0] issue_addr;
  logic [FS-1:0]     issue_data;
  logic [CW-1:0]     issue_cnt;

  logic              ram_we_q, loaded_q, ovf_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [FS-1:0]     ram_wdata_q;
  logic [CW-1:0]     cnt_q;

  function automatic logic [CW-1:0] popcnt(input logic [FS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < FS; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // ---------------- capture side ----------------
  assign bit_vld    = en_activ && (int'(neur_idx) < FS);
  assign cmpl       = bit_vld && (int'(neur_idx) == FS-1);
  assign first      = bit_vld && (neur_idx == '0);
  // The buffer is free again in the cycle its last lane is issued.
  assign last_issue = (state_q == W_WRITE) && (int'(lane_q) == EC_SIZE-1);
  assign swap       = cmpl && (!wr_full_q || last_issue);
  assign drop       = cmpl && wr_full_q && !last_issue;

  always_comb begin
    cap_tag_d = cap_tag_q;
    if (first) begin
      cap_tag_d.oc = oc_phase;
      cap_tag_d.t  = time_step;
    end
  end

  for (genvar l = 0; l < EC_SIZE; l++) begin : g_lane
    spk_train_lane #(.FS(FS), .NW(NW)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .wr_bit_i (bit_vld),
      .idx_i    (neur_idx),
      .spk_i    (spk_in[l]),
      .clr_i    (cmpl),
      .load_i   (swap),
      .wr_o     (wr_bufs[l])
    );
  end

  // ---------------- write side ----------------
  always_comb begin
    ch         = int'(wr_tag_q.oc) * EC_SIZE + int'(lane_q);
    // Lanes past the last channel of a partial group are silently skipped.
    issue_we   = (state_q == W_WRITE) && (ch < OUTPUT_CHANNELS);
    issue_addr = ADDR_W'(ch * TIME_STEPS + int'(wr_tag_q.t));
    issue_data = wr_bufs[lane_q];
    issue_cnt  = popcnt(issue_data);
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    wr_full_d = wr_full_q;
    insweep_d = insweep_q;
    pend_d    = pend_q;

    if (swap)            wr_full_d = 1'b1;
    else if (last_issue) wr_full_d = 1'b0;

    if (cmpl)         insweep_d = 1'b0;
    else if (bit_vld) insweep_d = 1'b1;

    if (layer_done)              pend_d = 1'b1;
    else if (state_q == W_DONE)  pend_d = 1'b0;

    case (state_q)
      W_IDLE: begin
        // Swap and start of drain share an edge to keep 2-cycle latency.
        if (swap || wr_full_q) begin
          state_d = W_WRITE;
          lane_d  = '0;
        end else if (pend_q && !insweep_q && !bit_vld) begin
          state_d = W_DONE;
        end
      end
      W_WRITE: begin
        lane_d = lane_q + LW'(1);
        if (last_issue) begin
          lane_d  = '0;
          state_d = swap ? W_WRITE : W_IDLE;
        end
      end
      W_DONE:  state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= W_IDLE;
      lane_q      <= '0;
      wr_full_q   <= 1'b0;
      insweep_q   <= 1'b0;
      pend_q      <= 1'b0;
      cap_tag_q   <= '0;
      wr_tag_q    <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cnt_q       <= '0;
      loaded_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      wr_full_q <= wr_full_d;
      insweep_q <= insweep_d;
      pend_q    <= pend_d;
      cap_tag_q <= cap_tag_d;
      if (swap) wr_tag_q <= cap_tag_d;
      ram_we_q  <= issue_we;
      if (issue_we) begin
        ram_addr_q  <= issue_addr;
        ram_wdata_q <= issue_data;
        cnt_q       <= issue_cnt;
      end
      loaded_q <= (state_d == W_DONE);
      ovf_q    <= ovf_q | drop;
    end
  end

  assign ram_we              = ram_we_q;
  assign ram_addr            = ram_addr_q;
  assign ram_wdata           = ram_wdata_q;
  assign frame_spk_cnt       = cnt_q;
  assign post_syn_RAM_loaded = loaded_q;
  assign overflow_err        = ovf_q;
endmodule
